// File: rtl/fb_pkg.sv
// Shared constants and fill FSM state encoding for the frame-buffer arbiter.
package fb_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 6;
  localparam int DEPTH  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;
endpackage

// File: rtl/fb_fill_gen.sv
// Whole-frame fill sequencer: FSM, fill address counter and colour captured at start.
module fb_fill_gen #(
  parameter int ADDR_W = fb_pkg::ADDR_W,
  parameter int DATA_W = fb_pkg::DATA_W,
  parameter int DEPTH  = fb_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_start_i,
  input  logic [DATA_W-1:0] fill_color_i,
  input  logic              grant_i,
  output logic [1:0]        state_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] color_o
);
  import fb_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] color_q, color_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      color_q <= color_d;
    end
  end

  // The last address holds instead of incrementing, so the counter never wraps.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    color_d = color_q;
    case (state_q)
      ST_IDLE: begin
        if (fill_start_i) begin
          state_d = ST_FILL;
          addr_d  = '0;
          color_d = fill_color_i;
        end
      end
      ST_FILL: begin
        if (grant_i) begin
          if (addr_q == LAST_ADDR) state_d = ST_DONE;
          else                     addr_d  = addr_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign state_o = state_q;
  assign addr_o  = addr_q;
  assign color_o = color_q;
endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-memory arbiter: display reads vs host/fill writes with starvation guard.
// Handshake: a port transfers when valid && ready; ready never looks at its own valid.
module fb_arbiter #(
  parameter int ADDR_W     = fb_pkg::ADDR_W,
  parameter int DATA_W     = fb_pkg::DATA_W,
  parameter int DEPTH      = fb_pkg::DEPTH,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_data_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);
  import fb_pkg::*;

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [1:0]        fill_state;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_color_q;
  logic              in_idle, in_fill;
  logic              wr_pend, starve_full, ws_open;
  logic              rd_grant, host_grant, fill_grant;

  logic [SW-1:0]     starve_q, starve_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rd_pend_q, rd_dv_q;

  fb_fill_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fill_gen (
    .clk          (clk),
    .rst          (rst),
    .fill_start_i (fill_start),
    .fill_color_i (fill_color),
    .grant_i      (fill_grant),
    .state_o      (fill_state),
    .addr_o       (fill_addr),
    .color_o      (fill_color_q)
  );

  // Write side = host write in IDLE or fill write in FILL; DONE accepts neither.
  assign in_idle     = (fill_state == ST_IDLE);
  assign in_fill     = (fill_state == ST_FILL);
  assign wr_pend     = in_fill || (in_idle && wr_valid);
  assign starve_full = (starve_q == SW'(STARVE_MAX));
  assign ws_open     = !rd_valid || starve_full;

  assign rd_ready    = !(starve_full && wr_pend);
  assign wr_ready    = in_idle && ws_open;
  assign rd_grant    = rd_valid && rd_ready;
  assign host_grant  = wr_valid && wr_ready;
  assign fill_grant  = in_fill && ws_open;

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    starve_d    = starve_q;
    if (rd_grant) begin
      mem_addr_d = rd_addr;
    end else if (fill_grant) begin
      mem_addr_d  = fill_addr;
      mem_we_d    = 1'b1;
      mem_wdata_d = fill_color_q;
    end else if (host_grant) begin
      mem_addr_d  = wr_addr;
      mem_we_d    = 1'b1;
      mem_wdata_d = wr_data;
    end
    if (!wr_pend || fill_grant || host_grant) starve_d = '0;
    else if (!starve_full)                    starve_d = starve_q + 1'b1;
  end

  // Read data returns two edges after the grant: address register, then memory register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q    <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_dv_q     <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rd_pend_q   <= rd_grant;
      rd_dv_q     <= rd_pend_q;
    end
  end

  assign mem_addr      = mem_addr_q;
  assign mem_we        = mem_we_q;
  assign mem_wdata     = mem_wdata_q;
  assign rd_data_valid = rd_dv_q;
  assign rd_data       = mem_rdata;
  assign fill_busy     = !in_idle;
  assign fill_done     = (fill_state == ST_DONE);
  assign dbg_state     = fill_state;
endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a registered-read memory model and read-return scoreboard.
module tb_fb_arbiter;
  localparam int AW = 10;
  localparam int DW = 6;
  localparam int DP = 16;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rd_valid, rd_ready, rd_data_valid;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          fill_start, fill_busy, fill_done;
  logic [DW-1:0] fill_color;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    dbg_state;

  logic [DW-1:0] mem [0:1023];
  logic          mem_init = 1'b0;

  logic [DW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            fill_wr_cnt = 0;
  int            done_cnt = 0;
  int            k_done;
  logic          fill_mon = 1'b0;
  logic [AW-1:0] fill_exp_addr = '0;
  logic [DW-1:0] fill_color_exp = '0;

  fb_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DP), .STARVE_MAX(SM)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .fill_start(fill_start), .fill_color(fill_color),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return a[5:0] ^ 6'h15;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    return (a == 10'd5) ? 6'h2A : pat(a);
  endfunction

  // memory model: one-cycle registered read, contents untouched by rst
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(AW'(i));
      mem[5]   <= 6'h2A;
      mem_init <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard and fill-write monitor, sampled mid-cycle
  task automatic sample();
    logic [DW-1:0] e;
    if (rst) begin
      exp_q.delete();
      fill_wr_cnt   = 0;
      fill_exp_addr = '0;
      return;
    end
    if (rd_data_valid) begin
      chk("rd_q_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rd_data", 32'(rd_data), 32'(e));
      end
    end
    if (rd_valid && rd_ready) exp_q.push_back(exp_rd(rd_addr));
    if (fill_done) done_cnt++;
    if (!fill_mon) begin
      fill_wr_cnt   = 0;
      fill_exp_addr = '0;
    end else if (mem_we) begin
      chk("fill_addr", 32'(mem_addr), 32'(fill_exp_addr));
      chk("fill_data", 32'(mem_wdata), 32'(fill_color_exp));
      chk("fill_in_range", 32'(fill_wr_cnt < DP), 1);
      fill_exp_addr = fill_exp_addr + 1'b1;
      fill_wr_cnt++;
    end
  endtask

  // driver step: sample at negedge, return just after the next posedge
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    for (int c = 0; c < 200 && !fill_done; c++) tick();
    chk(tag, 32'(fill_done), 1);
  endtask

  initial begin
    rd_valid = 0; rd_addr = '0; wr_valid = 0; wr_addr = '0; wr_data = '0;
    fill_start = 0; fill_color = '0;
    #1 rst = 1;
    #2;
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_rd_dv", 32'(rd_data_valid), 0);
    chk("rst_fill_busy", 32'(fill_busy), 0);
    chk("rst_fill_done", 32'(fill_done), 0);
    chk("rst_state", 32'(dbg_state), 0);
    repeat (2) tick();
    rst = 0;
    tick();

    // single read of preloaded address 5
    rd_valid = 1; rd_addr = 10'd5;
    #1;
    chk("a_rd_ready", 32'(rd_ready), 1);
    chk("a_wr_ready", 32'(wr_ready), 0);
    tick();
    rd_valid = 0;
    chk("a_mem_addr", 32'(mem_addr), 5);
    chk("a_mem_we", 32'(mem_we), 0);
    chk("a_dv_early", 32'(rd_data_valid), 0);
    tick();
    chk("a_dv", 32'(rd_data_valid), 1);
    chk("a_rd_data", 32'(rd_data), 32'h2A);
    tick();
    chk("a_dv_off", 32'(rd_data_valid), 0);
    chk("a_addr_hold", 32'(mem_addr), 5);

    // 4:1 read/write ratio under contention
    rd_valid = 1; rd_addr = 10'd300; wr_valid = 1; wr_addr = 10'd200; wr_data = 6'h11;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("b_rd_ready", 32'(rd_ready), 32'(i % 5 != 4));
      chk("b_wr_ready", 32'(wr_ready), 32'(i % 5 == 4));
      tick();
      chk("b_mem_we", 32'(mem_we), 32'(i % 5 == 4));
      if (i % 5 == 4) begin
        chk("b_wr_addr", 32'(mem_addr), 200);
        chk("b_wr_data", 32'(mem_wdata), 32'h11);
      end
    end
    rd_valid = 0; wr_valid = 0;
    repeat (3) tick();
    chk("b_q_drained", 32'(exp_q.size()), 0);

    // fill with host write in the start cycle, then host write held during fill
    done_cnt = 0;
    fill_color = 6'h3F; fill_color_exp = 6'h3F; fill_start = 1;
    wr_valid = 1; wr_addr = 10'd240; wr_data = 6'h05;
    #1;
    chk("c_wr_ready_start", 32'(wr_ready), 1);
    chk("c_busy_pre", 32'(fill_busy), 0);
    tick();
    fill_start = 0; fill_color = 6'h00; wr_addr = 10'd250; wr_data = 6'h0A;
    chk("c_host_we", 32'(mem_we), 1);
    chk("c_host_addr", 32'(mem_addr), 240);
    chk("c_host_data", 32'(mem_wdata), 32'h05);
    chk("c_state_fill", 32'(dbg_state), 1);
    chk("c_busy", 32'(fill_busy), 1);
    tick();
    fill_mon = 1;
    for (int c = 0; c < 200 && !fill_done; c++) begin
      chk("c_wr_ready_fill", 32'(wr_ready), 0);
      tick();
    end
    chk("c_done", 32'(fill_done), 1);
    chk("c_wr_ready_done", 32'(wr_ready), 0);
    chk("c_state_done", 32'(dbg_state), 2);
    chk("c_busy_done", 32'(fill_busy), 1);
    tick();
    chk("c_wr_cnt", 32'(fill_wr_cnt), 16);
    chk("c_done_cnt", 32'(done_cnt), 1);
    chk("c_state_idle", 32'(dbg_state), 0);
    chk("c_done_off", 32'(fill_done), 0);
    chk("c_busy_off", 32'(fill_busy), 0);
    chk("c_wr_ready_idle", 32'(wr_ready), 1);
    fill_mon = 0;
    tick();
    wr_valid = 0;
    chk("c_late_we", 32'(mem_we), 1);
    chk("c_late_addr", 32'(mem_addr), 250);
    chk("c_late_data", 32'(mem_wdata), 32'h0A);
    tick();
    chk("c_idle_we", 32'(mem_we), 0);

    // fill with reads held: every 5th fill cycle is a write
    done_cnt = 0; k_done = -1;
    rd_valid = 1; rd_addr = 10'd400; fill_color = 6'h3F; fill_start = 1;
    tick();
    fill_start = 0; rd_addr = rd_addr + 1'b1;
    chk("d_state_fill", 32'(dbg_state), 1);
    fill_mon = 1;
    for (int k = 0; k < 200; k++) begin
      tick();
      chk("d_we_pattern", 32'(mem_we), 32'(k % 5 == 4));
      if (k % 5 != 4) rd_addr = rd_addr + 1'b1;
      if (fill_done) begin
        k_done = k;
        break;
      end
    end
    rd_valid = 0;
    chk("d_fill_cycles", 32'(k_done), 79);
    tick();
    chk("d_wr_cnt", 32'(fill_wr_cnt), 16);
    chk("d_done_cnt", 32'(done_cnt), 1);
    fill_mon = 0;
    repeat (3) tick();
    chk("d_q_drained", 32'(exp_q.size()), 0);

    // reset in the middle of a fill, then restart from address 0
    done_cnt = 0;
    fill_start = 1;
    tick();
    fill_start = 0;
    fill_mon = 1;
    for (int c = 0; c < 50 && fill_wr_cnt < 7; c++) tick();
    chk("e_seven_writes", 32'(fill_wr_cnt), 7);
    #2 rst = 1;
    #1;
    chk("e_rst_we", 32'(mem_we), 0);
    chk("e_rst_addr", 32'(mem_addr), 0);
    chk("e_rst_wdata", 32'(mem_wdata), 0);
    chk("e_rst_dv", 32'(rd_data_valid), 0);
    chk("e_rst_busy", 32'(fill_busy), 0);
    chk("e_rst_done", 32'(fill_done), 0);
    chk("e_rst_state", 32'(dbg_state), 0);
    repeat (2) tick();
    rst = 0;
    chk("e_no_done", 32'(done_cnt), 0);
    fill_start = 1;
    tick();
    fill_start = 0;
    wait_done("e_done_to");
    tick();
    chk("e_wr_cnt", 32'(fill_wr_cnt), 16);
    chk("e_done_cnt", 32'(done_cnt), 1);
    fill_mon = 0;
    tick();
    chk("final_q_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, frame-memory address width.
REQ-002 Parameter DATA_W, default 6, pixel width.
REQ-003 Parameter DEPTH, default 1024, number of addressed words; fill sweeps 0..DEPTH-1.
REQ-004 Parameter STARVE_MAX, default 4, consecutive denied write-side cycles before a forced write grant.
REQ-005 clk  in  1  single clock, all state on posedge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 rd_valid  in  1  display read request; rd_addr in ADDR_W; rd_ready out 1.
REQ-008 rd_data_valid  out  1  read return strobe; rd_data out DATA_W.
REQ-009 wr_valid  in  1  host write request; wr_addr in ADDR_W; wr_data in DATA_W; wr_ready out 1.
REQ-010 fill_start  in  1  pulse, start whole-frame fill; fill_color in DATA_W; fill_busy out 1; fill_done out 1 (one-cycle pulse).
REQ-011 mem_addr  out  ADDR_W; mem_we out 1; mem_wdata out DATA_W; mem_rdata in DATA_W (memory registers read data one cycle after address).

Function
REQ-012 A transfer occurs on a port in a cycle where valid and ready are both 1; the block grants at most one memory access per cycle.
REQ-013 rd_ready and wr_ready are combinational from arbitration state and the other requester's valid; neither depends on its own valid.
REQ-014 Write side = host write (state IDLE) or fill write (state FILL); in FILL, wr_ready = 0.
REQ-015 Priority: read wins when rd_valid = 1, unless the starve counter equals STARVE_MAX, in which case the write side wins and rd_ready = 0.
REQ-016 Starve counter increments, saturating at STARVE_MAX, in each cycle the write side is pending and denied; it clears on a write-side grant or when no write is pending.
REQ-017 A grant at edge N drives mem_addr, mem_we, and mem_wdata as registers valid during cycle N+1; mem_we = 0 for read grants and idle cycles.
REQ-018 A read granted at edge N yields rd_data_valid = 1 during cycle N+2 with rd_data = mem_rdata; returns keep request order.
REQ-019 FSM states: IDLE, FILL, DONE.
REQ-020 IDLE -> FILL on the edge where fill_start = 1; the fill address loads 0.
REQ-021 In FILL, each write-side grant writes fill_color (captured at start) to the fill address, then increments the address.
REQ-022 FILL -> DONE after the write to DEPTH-1 is granted.
REQ-023 DONE -> IDLE unconditionally; fill_done = 1 in DONE only.
REQ-024 fill_busy = 1 in FILL and DONE.
REQ-025 fill_start is ignored outside IDLE; a host write handshaken in the fill_start cycle completes normally.
REQ-026 The fill address never wraps; no write reaches address DEPTH or beyond.
REQ-027 With no request pending, mem_we = 0 and mem_addr holds its last value.

Reset
REQ-028 While rst = 1, the outputs are: mem_we = 0, mem_addr = 0, mem_wdata = 0, rd_data_valid = 0, fill_busy = 0, fill_done = 0, state IDLE, starve counter 0, fill address 0.
REQ-029 Reset mid-fill aborts the fill with no fill_done; reset drops in-flight read returns; memory contents are not touched.

Structure
REQ-030 Shared package fb_pkg holds DATA_W, ADDR_W, DEPTH, and the FSM state enum.
REQ-031 Sub-module fb_fill_gen holds the fill FSM, fill address counter, and captured colour; fb_arbiter holds the arbitration, starve counter, and output registers.

Verification
REQ-032 Scenario: rd_valid = 1 at addr 5 in one cycle, with memory preloaded 5 -> 6'h2A. Required: mem_addr = 5 and mem_we = 0 in the next cycle; rd_data_valid = 1 and rd_data = 6'h2A two cycles after the grant.
REQ-033 Scenario: rd_valid and wr_valid held at 1, STARVE_MAX = 4. Required: 4 read grants, then 1 write grant (mem_we = 1, wr_ready = 1, rd_ready = 0), repeating 4:1.
REQ-034 Scenario: fill_start with fill_color = 6'h3F, DEPTH = 16, no reads. Required: exactly 16 writes to addresses 0..15, then fill_done pulses once, then IDLE.
REQ-035 Scenario: rd_valid held at 1 during the same fill. Required: the fill still completes (every 5th cycle is a write) and the read return order is preserved.
REQ-036 Scenario: rst = 1 asserted after the 7th fill write. Required: all outputs at reset values asynchronously, no fill_done, and fill_start after reset restarts from address 0.
REQ-037 Scenario: wr_valid = 1 during FILL. Required: wr_ready = 0 until the cycle after fill_done, then the write is accepted.
